gactx_kernel_ctrl: RTL and testbench

Parametrised ap_ctrl block controlling the GACTX kernel's per-bank channels. It detects the host start edge and sends a one-cycle start pulse to every enabled channel. It then collects sticky per-channel done pulses and reports kernel completion in either handshake (hs) or chain mode. A run-cycle counter and an optional watchdog abort hung runs. It sits between the s_axi_control register file and the NUM_CH memory-channel engines (ref/query/tile/traceback movers).

---
 rtl/gactx_kernel_ctrl_if.sv | 31 +++
 rtl/gactx_kernel_ctrl.sv | 142 ++++++++++++++
 tb/tb_gactx_kernel_ctrl.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/gactx_kernel_ctrl_if.sv
// Host/channel-facing signal bundle of the GACTX ap_ctrl block.
// The master side drives the host and channel requests. The slave side is the controller.
interface gactx_kernel_ctrl_if #(
  parameter int unsigned NUM_CH = 2,
  parameter int unsigned CYC_W  = 48,
  parameter int unsigned TMO_W  = 32
);
  logic              ap_start;
  logic              ap_continue;
  logic              ap_idle;
  logic              ap_done;
  logic              ap_ready;
  logic [NUM_CH-1:0] ch_enable;
  logic [TMO_W-1:0]  timeout_cycles;
  logic [NUM_CH-1:0] ch_start;
  logic [NUM_CH-1:0] ch_done;
  logic              ch_abort;
  logic [NUM_CH-1:0] done_mask;
  logic              timed_out;
  logic [CYC_W-1:0]  run_cycles;

  modport master (
    output ap_start, ap_continue, ch_enable, timeout_cycles, ch_done,
    input  ap_idle, ap_done, ap_ready, ch_start, ch_abort, done_mask, timed_out, run_cycles
  );

  modport slave (
    input  ap_start, ap_continue, ch_enable, timeout_cycles, ch_done,
    output ap_idle, ap_done, ap_ready, ch_start, ch_abort, done_mask, timed_out, run_cycles
  );
endinterface

// File: rtl/gactx_kernel_ctrl.sv
// ap_ctrl sequencer for the GACTX channel engines: it fans out the start pulse and collects
// sticky per-channel done bits. It completes in hs or chain mode and has a watchdog abort.
module gactx_kernel_ctrl #(
  parameter int unsigned NUM_CH     = 2,
  parameter int unsigned CYC_W      = 48,
  parameter int unsigned TMO_W      = 32,
  parameter bit          CHAIN_MODE = 1'b0
) (
  input  logic                ap_clk,
  input  logic                ap_rst_n,
  gactx_kernel_ctrl_if.slave  ctrl
);

  // Compare width wide enough that run_cycles + 1 never wraps against the limit.
  localparam int unsigned CmpW = (CYC_W + 1 > TMO_W) ? CYC_W + 1 : TMO_W;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e            state_q, state_d;
  logic              start_r_q;
  logic [NUM_CH-1:0] en_q, en_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic [NUM_CH-1:0] done_mask_q, done_mask_d;
  logic              timed_out_q, timed_out_d;
  logic [CYC_W-1:0]  run_cycles_q, run_cycles_d;
  logic [NUM_CH-1:0] ch_start_q, ch_start_d;
  logic              ch_abort_q, ch_abort_d;

  logic              start_pulse;
  logic [NUM_CH-1:0] mask_hit;
  logic              all_done;
  logic              tmo_hit;

  assign start_pulse = ctrl.ap_start & ~start_r_q;
  assign mask_hit    = done_mask_q | (ctrl.ch_done & en_q);
  assign all_done    = (mask_hit == en_q);
  assign tmo_hit     = (tmo_q != '0) &&
                       ((CmpW'(run_cycles_q) + CmpW'(1)) == CmpW'(tmo_q));

  // State register
  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (start_pulse) begin
          state_d = (ctrl.ch_enable != '0) ? StRun : StDone;
        end
      end
      StRun: begin
        if (all_done || tmo_hit) begin
          state_d = StDone;
        end
      end
      StDone: begin
        if (!CHAIN_MODE || ctrl.ap_continue) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Output logic
  always_comb begin
    ctrl.ap_idle  = (state_q == StIdle);
    ctrl.ap_done  = (state_q == StDone);
    ctrl.ap_ready = (state_q == StDone);
  end

  // Datapath next-state: run bookkeeping and the registered start/abort pulses
  always_comb begin
    en_d         = en_q;
    tmo_d        = tmo_q;
    done_mask_d  = done_mask_q;
    timed_out_d  = timed_out_q;
    run_cycles_d = run_cycles_q;
    ch_start_d   = '0;
    ch_abort_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start_pulse) begin
          en_d         = ctrl.ch_enable;
          tmo_d        = ctrl.timeout_cycles;
          done_mask_d  = '0;
          timed_out_d  = 1'b0;
          run_cycles_d = '0;
          ch_start_d   = ctrl.ch_enable;
        end
      end
      StRun: begin
        done_mask_d = mask_hit;
        if (run_cycles_q != '1) begin
          run_cycles_d = run_cycles_q + CYC_W'(1);
        end
        // Completion on the watchdog cycle takes priority over the abort.
        if (!all_done && tmo_hit) begin
          ch_abort_d  = 1'b1;
          timed_out_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      start_r_q    <= 1'b0;
      en_q         <= '0;
      tmo_q        <= '0;
      done_mask_q  <= '0;
      timed_out_q  <= 1'b0;
      run_cycles_q <= '0;
      ch_start_q   <= '0;
      ch_abort_q   <= 1'b0;
    end else begin
      start_r_q    <= ctrl.ap_start;
      en_q         <= en_d;
      tmo_q        <= tmo_d;
      done_mask_q  <= done_mask_d;
      timed_out_q  <= timed_out_d;
      run_cycles_q <= run_cycles_d;
      ch_start_q   <= ch_start_d;
      ch_abort_q   <= ch_abort_d;
    end
  end

  assign ctrl.ch_start   = ch_start_q;
  assign ctrl.ch_abort   = ch_abort_q;
  assign ctrl.done_mask  = done_mask_q;
  assign ctrl.timed_out  = timed_out_q;
  assign ctrl.run_cycles = run_cycles_q;

endmodule

// File: tb/tb_gactx_kernel_ctrl.sv
// Directed bench for gactx_kernel_ctrl with one hs-mode and one chain-mode instance.
// Each step drives the inputs just after a rising edge and samples the outputs on the falling edge.
module tb_gactx_kernel_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  gactx_kernel_ctrl_if #(.NUM_CH(2), .CYC_W(48), .TMO_W(32)) hs_if ();
  gactx_kernel_ctrl_if #(.NUM_CH(2), .CYC_W(48), .TMO_W(32)) cm_if ();

  gactx_kernel_ctrl #(.NUM_CH(2), .CYC_W(48), .TMO_W(32), .CHAIN_MODE(1'b0)) u_dut_hs (
    .ap_clk   (clk),
    .ap_rst_n (rst_n),
    .ctrl     (hs_if)
  );

  gactx_kernel_ctrl #(.NUM_CH(2), .CYC_W(48), .TMO_W(32), .CHAIN_MODE(1'b1)) u_dut_cm (
    .ap_clk   (clk),
    .ap_rst_n (rst_n),
    .ctrl     (cm_if)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic gap(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      hs_if.ap_start = 1'b0;
      hs_if.ch_done  = 2'b00;
    end
  endtask

  initial begin
    rst_n                = 1'b0;
    hs_if.ap_start       = 1'b0;
    hs_if.ap_continue    = 1'b0;
    hs_if.ch_enable      = 2'b00;
    hs_if.timeout_cycles = 32'd0;
    hs_if.ch_done        = 2'b00;
    cm_if.ap_start       = 1'b0;
    cm_if.ap_continue    = 1'b0;
    cm_if.ch_enable      = 2'b00;
    cm_if.timeout_cycles = 32'd0;
    cm_if.ch_done        = 2'b00;

    tick();
    tick();
    @(negedge clk);
    chk("rst_idle",  64'(hs_if.ap_idle),    64'd1);
    chk("rst_done",  64'(hs_if.ap_done),    64'd0);
    chk("rst_start", 64'(hs_if.ch_start),   64'd0);
    chk("rst_cyc",   64'(hs_if.run_cycles), 64'd0);
    chk("rst_cm_idle", 64'(cm_if.ap_idle),  64'd1);
    tick();
    rst_n = 1'b1;
    gap(2);

    // Both channels enabled, dones at cycles 5 and 9.
    hs_if.ch_enable      = 2'b11;
    hs_if.timeout_cycles = 32'd0;
    for (int c = 0; c <= 11; c++) begin
      tick();
      hs_if.ap_start = (c <= 1);
      hs_if.ch_done  = {c == 9, c == 5};
      @(negedge clk);
      chk("t1_done",  64'(hs_if.ap_done),  64'(c == 10));
      chk("t1_ready", 64'(hs_if.ap_ready), 64'(c == 10));
      chk("t1_start", 64'(hs_if.ch_start), (c == 1) ? 64'd3 : 64'd0);
      chk("t1_idle",  64'(hs_if.ap_idle),  64'(c == 0 || c == 11));
      if (c == 6)  chk("t1_mask6", 64'(hs_if.done_mask), 64'd1);
      if (c == 10) begin
        chk("t1_cyc",  64'(hs_if.run_cycles), 64'd9);
        chk("t1_mask", 64'(hs_if.done_mask),  64'd3);
        chk("t1_tmo",  64'(hs_if.timed_out),  64'd0);
      end
    end
    gap(2);

    // Only channel 0 enabled; the channel 1 done is ignored.
    hs_if.ch_enable = 2'b01;
    for (int c = 0; c <= 8; c++) begin
      tick();
      hs_if.ap_start = (c == 0);
      hs_if.ch_done  = {c == 3, c == 6};
      @(negedge clk);
      chk("t2_done",  64'(hs_if.ap_done),  64'(c == 7));
      chk("t2_start", 64'(hs_if.ch_start), (c == 1) ? 64'd1 : 64'd0);
      if (c == 4) chk("t2_mask4", 64'(hs_if.done_mask), 64'd0);
      if (c == 7) begin
        chk("t2_mask", 64'(hs_if.done_mask),  64'd1);
        chk("t2_cyc",  64'(hs_if.run_cycles), 64'd6);
      end
    end
    gap(2);

    // Empty enable mask goes straight to DONE.
    hs_if.ch_enable = 2'b00;
    for (int c = 0; c <= 2; c++) begin
      tick();
      hs_if.ap_start = (c == 0);
      hs_if.ch_done  = 2'b00;
      @(negedge clk);
      chk("t3_done",  64'(hs_if.ap_done),  64'(c == 1));
      chk("t3_start", 64'(hs_if.ch_start), 64'd0);
      chk("t3_idle",  64'(hs_if.ap_idle),  64'(c != 1));
      if (c == 1) begin
        chk("t3_mask", 64'(hs_if.done_mask),  64'd0);
        chk("t3_cyc",  64'(hs_if.run_cycles), 64'd0);
      end
    end
    gap(2);

    // Watchdog at 20 with channel 1 hung.
    hs_if.ch_enable      = 2'b11;
    hs_if.timeout_cycles = 32'd20;
    for (int c = 0; c <= 22; c++) begin
      tick();
      hs_if.ap_start = (c == 0);
      hs_if.ch_done  = {1'b0, c == 3};
      @(negedge clk);
      chk("t4_done",  64'(hs_if.ap_done),  64'(c == 21));
      chk("t4_abort", 64'(hs_if.ch_abort), 64'(c == 21));
      if (c == 21) begin
        chk("t4_tmo",  64'(hs_if.timed_out),  64'd1);
        chk("t4_cyc",  64'(hs_if.run_cycles), 64'd20);
        chk("t4_mask", 64'(hs_if.done_mask),  64'd1);
      end
      if (c == 22) begin
        chk("t4_idle",    64'(hs_if.ap_idle),   64'd1);
        chk("t4_tmohold", 64'(hs_if.timed_out), 64'd1);
      end
    end
    gap(2);

    // Last done lands on the watchdog cycle, so the run completes and the abort is suppressed.
    for (int c = 0; c <= 22; c++) begin
      tick();
      hs_if.ap_start = (c == 0);
      hs_if.ch_done  = {c == 20, c == 3};
      @(negedge clk);
      chk("t5_done",  64'(hs_if.ap_done),  64'(c == 21));
      chk("t5_abort", 64'(hs_if.ch_abort), 64'd0);
      if (c == 21) begin
        chk("t5_tmo",  64'(hs_if.timed_out),  64'd0);
        chk("t5_cyc",  64'(hs_if.run_cycles), 64'd20);
        chk("t5_mask", 64'(hs_if.done_mask),  64'd3);
      end
    end
    gap(2);

    // ap_start held high gives one run; the low cycle at 11 re-arms it for a second run.
    hs_if.timeout_cycles = 32'd0;
    for (int c = 0; c <= 16; c++) begin
      tick();
      hs_if.ap_start = (c != 11);
      hs_if.ch_done  = (c == 2 || c == 14) ? 2'b11 : 2'b00;
      @(negedge clk);
      chk("t6_start", 64'(hs_if.ch_start), (c == 1 || c == 13) ? 64'd3 : 64'd0);
      chk("t6_done",  64'(hs_if.ap_done),  64'(c == 3 || c == 15));
      chk("t6_idle",  64'(hs_if.ap_idle),
          64'(!((c >= 1 && c <= 3) || (c >= 13 && c <= 15))));
    end
    gap(2);

    // Reset in the middle of a run.
    hs_if.timeout_cycles = 32'd5;
    for (int c = 0; c <= 7; c++) begin
      tick();
      hs_if.ap_start = (c == 0);
      hs_if.ch_done  = {1'b0, c == 2};
      rst_n          = (c != 3);
      @(negedge clk);
      if (c == 3) chk("t7_mask3", 64'(hs_if.done_mask), 64'd1);
      if (c >= 4) begin
        chk("t7_idle",  64'(hs_if.ap_idle),    64'd1);
        chk("t7_done",  64'(hs_if.ap_done),    64'd0);
        chk("t7_ready", 64'(hs_if.ap_ready),   64'd0);
        chk("t7_abort", 64'(hs_if.ch_abort),   64'd0);
        chk("t7_start", 64'(hs_if.ch_start),   64'd0);
        chk("t7_mask",  64'(hs_if.done_mask),  64'd0);
        chk("t7_tmo",   64'(hs_if.timed_out),  64'd0);
        chk("t7_cyc",   64'(hs_if.run_cycles), 64'd0);
      end
    end
    gap(2);

    // Chain mode: done holds from cycle 8 until ap_continue at 15.
    cm_if.ch_enable = 2'b11;
    for (int c = 0; c <= 17; c++) begin
      tick();
      cm_if.ap_start    = (c == 0);
      cm_if.ch_done     = (c == 7) ? 2'b11 : 2'b00;
      cm_if.ap_continue = (c == 15);
      @(negedge clk);
      chk("t8_done",  64'(cm_if.ap_done),  64'(c >= 8 && c <= 15));
      chk("t8_ready", 64'(cm_if.ap_ready), 64'(c >= 8 && c <= 15));
      chk("t8_idle",  64'(cm_if.ap_idle),  64'(c == 0 || c >= 16));
      if (c == 8) chk("t8_cyc", 64'(cm_if.run_cycles), 64'd7);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
